// File: rtl/mul_iter_unit.sv
// mul_iter_unit: iterative shift-add multiplier for the RISC-V M-extension
// MUL / MULH / MULHSU / MULHU operations. It converts signed operands to
// magnitudes, accumulates BITS_PER_CYCLE partial products per cycle, and then
// applies the sign correction to the full product. Only one operation is in
// flight at a time.
//
// Ports
//   clk_i      : clock, rising edge
//   rst_i      : asynchronous reset, active low
//   valid_i    : operation request
//   ready_o    : unit is idle and can accept a request
//   op_i       : 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   ra_i, rb_i : operands a and b
//   tag_i      : pass-through tag (destination register index)
//   flush_i    : kill the in-flight operation
//   valid_o    : result available
//   ready_i    : consumer accepts the result
//   result_o   : selected half of the product
//   product_o  : full signed-corrected product
//   tag_o      : tag of the result

module mul_iter_unit #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 4,
    parameter int TAG_W          = 5
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [1:0]         op_i,
    input  logic [WIDTH-1:0]   ra_i,
    input  logic [WIDTH-1:0]   rb_i,
    input  logic [TAG_W-1:0]   tag_i,
    input  logic               flush_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [WIDTH-1:0]   result_o,
    output logic [2*WIDTH-1:0] product_o,
    output logic [TAG_W-1:0]   tag_o
);

    localparam int N     = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t state_q, state_d;

    logic                 armed_q;     // low until the first edge after reset release
    logic [1:0]           op_q;
    logic [TAG_W-1:0]     tag_q;
    logic [2*WIDTH-1:0]   ma_q;        // multiplicand magnitude, shifted left each cycle
    logic [WIDTH-1:0]     mb_q;        // multiplier magnitude, shifted right each cycle
    logic                 neg_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [2*WIDTH-1:0]   product_q;

    logic                 accept;
    logic                 last_beat;
    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [2*WIDTH-1:0]   pp_sum;
    logic [2*WIDTH-1:0]   acc_next;

    assign ready_o   = armed_q && (state_q == IDLE);
    assign valid_o   = (state_q == DONE);
    assign accept    = valid_i && ready_o && !flush_i;
    assign last_beat = (cnt_q == CNT_LAST);

    // MUL uses the low half, which is identical for signed and unsigned
    // operands, so it runs as unsigned.
    assign a_neg = ((op_i == OP_MULH) || (op_i == OP_MULHSU)) && ra_i[WIDTH-1];
    assign b_neg = (op_i == OP_MULH) && rb_i[WIDTH-1];
    // The most-negative value negates to itself, which read as unsigned is
    // exactly 2^(WIDTH-1), the magnitude we want.
    assign mag_a = a_neg ? (~ra_i + 1'b1) : ra_i;
    assign mag_b = b_neg ? (~rb_i + 1'b1) : rb_i;

    // NOTE: every variable assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        pp_sum = '0;
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            if (mb_q[k]) begin
                pp_sum = pp_sum + (ma_q << k);
            end
        end
        acc_next = acc_q + pp_sum;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = BUSY;
            BUSY: begin
                if (flush_i)        state_d = IDLE;
                else if (last_beat) state_d = DONE;
            end
            DONE: begin
                // Flush wins over ready: the result is not transferred.
                if (flush_i)        state_d = IDLE;
                else if (ready_i)   state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            armed_q <= 1'b1;
        end
    end

    // NOTE: the datapath is a handful of flops, not a memory array, so all of
    // it is reset; outputs read as zero during and right after reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            op_q      <= '0;
            tag_q     <= '0;
            ma_q      <= '0;
            mb_q      <= '0;
            neg_q     <= 1'b0;
            cnt_q     <= '0;
            acc_q     <= '0;
            product_q <= '0;
        end else if (accept) begin
            op_q  <= op_i;
            tag_q <= tag_i;
            ma_q  <= {{WIDTH{1'b0}}, mag_a};
            mb_q  <= mag_b;
            neg_q <= a_neg ^ b_neg;
            cnt_q <= '0;
            acc_q <= '0;
        end else if ((state_q == BUSY) && !flush_i) begin
            acc_q <= acc_next;
            ma_q  <= ma_q << BITS_PER_CYCLE;
            mb_q  <= mb_q >> BITS_PER_CYCLE;
            if (last_beat) begin
                cnt_q     <= '0;
                product_q <= neg_q ? (~acc_next + 1'b1) : acc_next;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign product_o = product_q;
    assign tag_o     = tag_q;
    assign result_o  = (op_q == OP_MUL) ? product_q[WIDTH-1:0]
                                        : product_q[2*WIDTH-1:WIDTH];

endmodule

// File: tb/tb_mul_iter_unit.sv
// Self-checking bench for mul_iter_unit at WIDTH=32, BITS_PER_CYCLE=4.
// Expected results come from a reference model that multiplies sign/zero
// extended operands directly; they are queued at issue and compared when
// valid_o rises.

module tb_mul_iter_unit;

    localparam int W   = 32;
    localparam int BPC = 4;
    localparam int TW  = 5;
    localparam int N   = W / BPC;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          valid_i;
    logic          ready_o;
    logic [1:0]    op_i;
    logic [W-1:0]  ra_i, rb_i;
    logic [TW-1:0] tag_i;
    logic          flush_i;
    logic          valid_o;
    logic          ready_i;
    logic [W-1:0]  result_o;
    logic [2*W-1:0] product_o;
    logic [TW-1:0] tag_o;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int last_accept = 0;

    typedef struct packed {
        logic [W-1:0]   res;
        logic [2*W-1:0] prod;
        logic [TW-1:0]  tag;
    } exp_t;

    exp_t sb[$];

    mul_iter_unit #(.WIDTH(W), .BITS_PER_CYCLE(BPC), .TAG_W(TW)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .op_i      (op_i),
        .ra_i      (ra_i),
        .rb_i      (rb_i),
        .tag_i     (tag_i),
        .flush_i   (flush_i),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .result_o  (result_o),
        .product_o (product_o),
        .tag_o     (tag_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic [TW-1:0] t);
        logic [2*W-1:0] ax, bx, p;
        exp_t e;
        ax = (op == 2'b01 || op == 2'b10) ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
        bx = (op == 2'b01) ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
        p  = ax * bx;
        e.prod = p;
        e.res  = (op == 2'b00) ? p[W-1:0] : p[2*W-1:W];
        e.tag  = t;
        return e;
    endfunction

    // Wait for ready_o, present one request, scramble inputs after acceptance.
    task automatic issue(input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [TW-1:0] t);
        int g = 0;
        while (!ready_o && g < 50) begin
            @(posedge clk_i); #1; g++;
        end
        checks++;
        if (!ready_o) begin
            errors++;
            $display("FAIL issue_wait_ready: ready_o=%0b required 1 within 50 cycles", ready_o);
        end
        valid_i = 1'b1; op_i = op; ra_i = a; rb_i = b; tag_i = t;
        sb.push_back(model(op, a, b, t));
        @(posedge clk_i); #1;
        last_accept = cyc;
        valid_i = 1'b0;
        op_i = 2'($urandom); ra_i = $urandom; rb_i = $urandom; tag_i = TW'($urandom);
    endtask

    // Wait for valid_o (bounded), check latency and compare against the queue.
    task automatic wait_result(input string name);
        int lat = 0;
        exp_t e;
        do begin
            @(posedge clk_i); #1; lat++;
        end while (!valid_o && lat < 50);
        checks++;
        if (!valid_o || lat != N) begin
            errors++;
            $display("FAIL %s_latency: valid_o=%0b after %0d edges, required 1 after %0d", name, valid_o, lat, N);
        end
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s_scoreboard: queue empty, required one entry", name);
            return;
        end
        e = sb.pop_front();
        checks++;
        if (result_o !== e.res) begin
            errors++;
            $display("FAIL %s_result: got %h required %h", name, result_o, e.res);
        end
        checks++;
        if (product_o !== e.prod) begin
            errors++;
            $display("FAIL %s_product: got %h required %h", name, product_o, e.prod);
        end
        checks++;
        if (tag_o !== e.tag) begin
            errors++;
            $display("FAIL %s_tag: got %0d required %0d", name, tag_o, e.tag);
        end
    endtask

    task automatic consume(input string name);
        ready_i = 1'b1;
        @(posedge clk_i); #1;
        ready_i = 1'b0;
        checks++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
            errors++;
            $display("FAIL %s_handoff: valid_o=%0b ready_o=%0b required 0/1", name, valid_o, ready_o);
        end
    endtask

    task automatic test_reset;
        rst_i = 1'b0; valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b0;
        op_i = '0; ra_i = '0; rb_i = '0; tag_i = '0;
        #3;
        checks++;
        if (ready_o !== 1'b0 || valid_o !== 1'b0 || result_o !== '0 ||
            product_o !== '0 || tag_o !== '0) begin
            errors++;
            $display("FAIL reset_state: ready=%0b valid=%0b res=%h prod=%h tag=%0d required all 0",
                     ready_o, valid_o, result_o, product_o, tag_o);
        end
        repeat (2) @(posedge clk_i);
        @(negedge clk_i); rst_i = 1'b1;
        #1;
        checks++;
        if (ready_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_before_edge: ready_o=%0b required 0", ready_o);
        end
        @(posedge clk_i); #1;
        checks++;
        if (ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_edge: ready_o=%0b required 1", ready_o);
        end
    endtask

    task automatic test_mul_basic;
        issue(2'b00, 32'd7, 32'd6, 5'd3);
        wait_result("mul_7x6");
        checks++;
        if (result_o !== 32'h0000_002A || tag_o !== 5'd3) begin
            errors++;
            $display("FAIL mul_7x6_literal: res=%h tag=%0d required 0000002a/3", result_o, tag_o);
        end
        consume("mul_7x6");
    endtask

    task automatic test_corners;
        issue(2'b01, 32'h8000_0000, 32'h8000_0000, 5'd1);
        wait_result("mulh_minneg");
        checks++;
        if (result_o !== 32'h4000_0000 || product_o !== 64'h4000_0000_0000_0000) begin
            errors++;
            $display("FAIL mulh_minneg_literal: res=%h prod=%h required 40000000/4000000000000000", result_o, product_o);
        end
        consume("mulh_minneg");

        issue(2'b00, 32'h8000_0000, 32'h8000_0000, 5'd2);
        wait_result("mul_minneg");
        checks++;
        if (result_o !== 32'h0) begin
            errors++;
            $display("FAIL mul_minneg_literal: res=%h required 00000000", result_o);
        end
        consume("mul_minneg");

        issue(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4);
        wait_result("mulhsu_ones");
        checks++;
        if (product_o !== 64'hFFFF_FFFF_0000_0001 || result_o !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL mulhsu_ones_literal: prod=%h res=%h required ffffffff00000001/ffffffff", product_o, result_o);
        end
        consume("mulhsu_ones");

        issue(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5);
        wait_result("mulhu_ones");
        checks++;
        if (result_o !== 32'hFFFF_FFFE) begin
            errors++;
            $display("FAIL mulhu_ones_literal: res=%h required fffffffe", result_o);
        end
        consume("mulhu_ones");

        // Zero operand still takes the full latency (checked in wait_result).
        issue(2'b01, 32'h0, 32'h1234_5678, 5'd6);
        wait_result("mulh_zero");
        consume("mulh_zero");
    endtask

    task automatic test_backpressure;
        logic [W-1:0]   r;
        logic [2*W-1:0] p;
        logic [TW-1:0]  t;
        issue(2'b01, 32'hFFFF_FFF9, 32'd1000, 5'd9);
        wait_result("bp");
        r = sb.size() == 0 ? model(2'b01, 32'hFFFF_FFF9, 32'd1000, 5'd9).res : '0;
        p = model(2'b01, 32'hFFFF_FFF9, 32'd1000, 5'd9).prod;
        t = 5'd9;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_i); #1;
            checks++;
            if (valid_o !== 1'b1 || ready_o !== 1'b0 || result_o !== r ||
                product_o !== p || tag_o !== t) begin
                errors++;
                $display("FAIL bp_hold_%0d: valid=%0b ready=%0b res=%h prod=%h tag=%0d required 1/0/%h/%h/%0d",
                         i, valid_o, ready_o, result_o, product_o, tag_o, r, p, t);
            end
        end
        consume("bp");
    endtask

    task automatic test_flush;
        int seen = 0;
        // flush_i together with valid_i in IDLE: ignored, nothing accepted.
        valid_i = 1'b1; flush_i = 1'b1; op_i = 2'b00; ra_i = 32'd2; rb_i = 32'd2;
        @(posedge clk_i); #1;
        valid_i = 1'b0; flush_i = 1'b0;
        checks++;
        if (ready_o !== 1'b1) begin
            errors++;
            $display("FAIL flush_idle_ready: ready_o=%0b required 1", ready_o);
        end

        issue(2'b00, 32'd100, 32'd200, 5'd7);
        void'(sb.pop_back());
        repeat (2) begin @(posedge clk_i); #1; end
        flush_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        checks++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_busy: ready_o=%0b valid_o=%0b required 1/0", ready_o, valid_o);
        end
        // Also a flush in DONE, with ready_i high: result must be dropped.
        issue(2'b00, 32'd3, 32'd3, 5'd8);
        void'(sb.pop_back());
        repeat (N) begin @(posedge clk_i); #1; end
        flush_i = 1'b1; ready_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i = 1'b0; ready_i = 1'b0;
        checks++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_done: ready_o=%0b valid_o=%0b required 1/0", ready_o, valid_o);
        end
        for (int i = 0; i < 12; i++) begin
            @(posedge clk_i); #1;
            if (valid_o) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL flush_no_valid: valid_o high %0d cycles required 0", seen);
        end
        issue(2'b11, 32'd3, 32'd5, 5'd10);
        wait_result("flush_followup");
        checks++;
        if (result_o !== 32'h0) begin
            errors++;
            $display("FAIL flush_followup_literal: res=%h required 00000000", result_o);
        end
        consume("flush_followup");
    endtask

    task automatic test_reset_midbusy;
        int seen = 0;
        issue(2'b11, 32'hDEAD_BEEF, 32'h1234_5678, 5'd11);
        repeat (3) begin @(posedge clk_i); #1; end
        rst_i = 1'b0;
        #1;
        checks++;
        if (valid_o !== 1'b0 || ready_o !== 1'b0 || product_o !== '0 || tag_o !== '0) begin
            errors++;
            $display("FAIL reset_midbusy: valid=%0b ready=%0b prod=%h tag=%0d required 0/0/0/0",
                     valid_o, ready_o, product_o, tag_o);
        end
        sb.delete();
        @(negedge clk_i); rst_i = 1'b1;
        @(posedge clk_i); #1;
        checks++;
        if (ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_midbusy_release: ready_o=%0b required 1", ready_o);
        end
        for (int i = 0; i < 12; i++) begin
            @(posedge clk_i); #1;
            if (valid_o) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_midbusy_stale: valid_o high %0d cycles required 0", seen);
        end
    endtask

    task automatic test_back_to_back;
        int prev = 0;
        for (int i = 0; i < 10; i++) begin
            issue(2'($urandom), $urandom, $urandom, TW'(i));
            if (i > 0) begin
                checks++;
                if (last_accept - prev != N + 2) begin
                    errors++;
                    $display("FAIL b2b_interval_%0d: %0d cycles required %0d", i, last_accept - prev, N + 2);
                end
            end
            prev = last_accept;
            wait_result($sformatf("b2b_%0d", i));
            ready_i = 1'b1;
            @(posedge clk_i); #1;
            ready_i = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_mul_basic();
        test_corners();
        test_backpressure();
        test_flush();
        test_reset_midbusy();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mul_iter_unit.md
MUL_ITER_UNIT -- requirements
Module: mul_iter_unit

Parameters
REQ-001 SHALL have parameter WIDTH, default 32: operand and result width, even, 8..64.
REQ-002 SHALL have parameter BITS_PER_CYCLE, default 4: multiplier bits retired per busy cycle; divides WIDTH; 1, 2, 4 or 8.
REQ-003 SHALL have parameter TAG_W, default 5: width of the pass-through tag (destination register index).

Interface
REQ-004 SHALL have clk_i, input, 1: single clock, rising edge.
REQ-005 SHALL have rst_i, input, 1: asynchronous reset, active-low.
REQ-006 SHALL have valid_i, input, 1: operation request.
REQ-007 SHALL have ready_o, output, 1: unit can accept a request.
REQ-008 SHALL have op_i, input, 2: 00 MUL (low half), 01 MULH (s*s high), 10 MULHSU (s*u high), 11 MULHU (u*u high).
REQ-009 SHALL have ra_i and rb_i, input, WIDTH each: operands a and b.
REQ-010 SHALL have tag_i, input, TAG_W: request tag.
REQ-011 SHALL have flush_i, input, 1: kill the in-flight operation.
REQ-012 SHALL have valid_o, output, 1: result available.
REQ-013 SHALL have ready_i, input, 1: consumer accepts the result.
REQ-014 SHALL have result_o, output, WIDTH: selected half of the product.
REQ-015 SHALL have product_o, output, 2*WIDTH: full signed-corrected product.
REQ-016 SHALL have tag_o, output, TAG_W: tag of the result.

Function
REQ-017 SHALL implement FSM states IDLE, BUSY and DONE; ready_o is 1 only in IDLE, and valid_o is 1 only in DONE.
REQ-018 SHALL accept a request on a rising edge with valid_i=1, ready_o=1 and flush_i=0, and on that edge SHALL register op, tag, operand magnitudes and the negate flag, then go to BUSY.
REQ-019 SHALL derive operand signedness from op: a is signed for MULH and MULHSU; b is signed only for MULH; MUL is treated as unsigned.
REQ-020 SHALL take the magnitude of a signed negative operand by two's complement; the most-negative value SHALL yield magnitude 2^(WIDTH-1), and the sign flag SHALL be the XOR of the operand sign flags.
REQ-021 SHALL, in BUSY, add BITS_PER_CYCLE partial products of the unsigned magnitudes into a 2*WIDTH accumulator on each edge, using a counter of N = WIDTH/BITS_PER_CYCLE cycles.
REQ-022 SHALL, on the Nth BUSY edge, two's-complement negate the accumulator if the sign flag is set, register it into product_o, and enter DONE.
REQ-023 SHALL raise valid_o exactly N edges after the accepting edge (8 for the defaults).
REQ-024 SHALL drive result_o with product_o[WIDTH-1:0] for MUL and with product_o[2*WIDTH-1:WIDTH] otherwise.
REQ-025 SHALL hold valid_o, result_o, product_o and tag_o stable while in DONE with ready_i=0.
REQ-026 SHALL, in DONE with ready_i=1, complete the transfer and go to IDLE, so ready_o rises on the next cycle.
REQ-027 SHALL make the minimum issue interval N+2 cycles, since there is no overlap of successive operations.
REQ-028 SHALL, on an edge with flush_i=1 in BUSY or DONE, go to IDLE, discard the result and not raise valid_o; flush_i in IDLE is ignored and valid_i in that cycle is not accepted.
REQ-029 SHALL give flush_i priority over ready_i in DONE; the result is counted as not transferred.
REQ-030 SHALL treat zero operands with no special timing: they take the full N cycles.
REQ-031 SHALL not modify the captured operands, op or tag from changes on ra_i, rb_i, op_i or tag_i after acceptance.

Reset
REQ-032 SHALL, while rst_i=0, immediately force state IDLE, ready_o=0, valid_o=0, and counter, accumulator, result_o, product_o and tag_o to 0, independent of clk_i.
REQ-033 SHALL raise ready_o on the first rising edge after rst_i deasserts.
REQ-034 SHALL abandon any operation in flight when reset asserts, and SHALL not produce valid_o for it after release.

Verification (WIDTH=32, BITS_PER_CYCLE=4)
REQ-035 SHALL cover: MUL, ra=7, rb=6, tag=3 -> valid_o 8 edges after accept, result_o=0x0000002A, tag_o=3.
REQ-036 SHALL cover: MULH, ra=rb=0x80000000 -> result_o=0x40000000 and product_o=0x4000000000000000; then MUL on the same operands -> result_o=0.
REQ-037 SHALL cover: MULHSU, ra=rb=0xFFFFFFFF -> product_o=0xFFFFFFFF00000001 and result_o=0xFFFFFFFF; MULHU on the same operands -> result_o=0xFFFFFFFE.
REQ-038 SHALL cover: ready_i held 0 for 5 cycles after valid_o -> outputs stable, ready_o=0 throughout; ready_i=1 -> ready_o=1 on the next cycle.
REQ-039 SHALL cover: flush_i pulsed on the 3rd BUSY edge -> valid_o never rises and ready_o=1 on the next cycle; a new MULHU 3*5 -> result_o=0.
REQ-040 SHALL cover: rst_i asserted mid-BUSY -> valid_o and ready_o go to 0 at once; after release, ready_o=1 on the first edge and no stale valid_o appears.
